ewm_tile_feeder: RTL

Streams operand tiles for the element-wise multiply stage: on `start` it reads `num_tiles` consecutive TILE_SIZE-lane words from two operand SRAMs (a = lambda, b = state/input) and presents them as paired `a_vec`/`b_vec` tiles on a valid/ready interface. It is the transmitter that sits upstream of the 4-lane EWM unit. It hides the fixed SRAM read latency with a credit-limited prefetch FIFO, so it sustains one tile per cycle and honours downstream backpressure without dropping data.

---
 rtl/ewm_tile_feeder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ewm_tile_feeder.sv
// ewm_tile_feeder: streams paired a/b operand tiles from two SRAMs to the EWM unit.
// Optional EWM_FEEDER_BCAST_A_EN adds bcast_a to hold rd_addr_a at base_a for a job.
module ewm_tile_feeder #(
  parameter int TILE_SIZE  = 4,
  parameter int IN_W       = 16,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               base_a,
  input  logic [ADDR_W-1:0]               base_b,
  input  logic [ADDR_W:0]                 num_tiles,
`ifdef EWM_FEEDER_BCAST_A_EN
  input  logic                            bcast_a,
`endif
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en,
  output logic [ADDR_W-1:0]               rd_addr_a,
  output logic [ADDR_W-1:0]               rd_addr_b,
  input  logic [TILE_SIZE-1:0][IN_W-1:0]  rd_data_a,
  input  logic [TILE_SIZE-1:0][IN_W-1:0]  rd_data_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TILE_SIZE-1:0][IN_W-1:0]  a_vec,
  output logic [TILE_SIZE-1:0][IN_W-1:0]  b_vec,
  output logic                            out_last
);

  localparam int NW = ADDR_W + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = TILE_SIZE * IN_W;

  if (FIFO_DEPTH < RD_LAT + 1) begin : g_bad_depth
    $error("ewm_tile_feeder: FIFO_DEPTH must be at least RD_LAT+1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [NW-1:0]     num_q;
  logic [NW-1:0]     issued;
  logic [NW-1:0]     popped;
  logic [RD_LAT-1:0] pipe;
  logic [2*TW-1:0]   mem [FIFO_DEPTH];
  logic [2*TW-1:0]   head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  int                inflight;
  int                credit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + int'(pipe[i]);
    end
  end

  assign pop    = out_valid && out_ready;
  assign push   = pipe[RD_LAT-1];
  assign credit = int'(count) + inflight - int'(pop);

  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == FIN);
  assign rd_en = (state == RUN) && (issued < num_q)
              && (credit < FIFO_DEPTH);

`ifdef EWM_FEEDER_BCAST_A_EN
  logic bcast_q;
  assign rd_addr_a = bcast_q ? base_a_q
                   : base_a_q + issued[ADDR_W-1:0];
`else
  assign rd_addr_a = base_a_q + issued[ADDR_W-1:0];
`endif
  assign rd_addr_b = base_b_q + issued[ADDR_W-1:0];

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign a_vec     = out_valid ? head[2*TW-1:TW] : '0;
  assign b_vec     = out_valid ? head[TW-1:0] : '0;
  assign out_last  = out_valid && (popped == num_q - NW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_a_q <= '0;
      base_b_q <= '0;
      num_q    <= '0;
      issued   <= '0;
      popped   <= '0;
`ifdef EWM_FEEDER_BCAST_A_EN
      bcast_q  <= 1'b0;
`endif
    end else begin
      if (rd_en) issued <= issued + NW'(1);
      if (pop)   popped <= popped + NW'(1);
      unique case (state)
        IDLE: if (start) begin
          base_a_q <= base_a;
          base_b_q <= base_b;
          num_q    <= num_tiles;
          issued   <= '0;
          popped   <= '0;
`ifdef EWM_FEEDER_BCAST_A_EN
          bcast_q  <= bcast_a;
`endif
          state    <= (num_tiles == '0) ? FIN : RUN;
        end
        RUN:   if (issued == num_q) state <= DRAIN;
        DRAIN: if (pop && out_last) state <= FIN;
        FIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Return-data marker: bit RD_LAT-1 flags the cycle rd_data is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {rd_data_a, rd_data_b};
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == CW'(FIFO_DEPTH)));

endmodule
